// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- instruction fetch controller for the IF stage
//
// Purpose:
//   Issues instruction-memory reads, hands returned instructions to IF/ID,
//   and drives the PC register load, PC mux select and PC mux target. It
//   owns no PC itself. A redirect seen while a read is outstanding is
//   remembered, and the matching response is dropped when it arrives, so the
//   fetch address stays stable for the whole request. A response that IF/ID
//   cannot take because of a stall is parked in a hold register and
//   re-presented until the stall clears.
//
// Handshake:
//   imem_read_o is held high in FETCH until imem_resp_i is seen high on a
//   rising clk edge. That edge completes the request, and imem_rdata_i is
//   taken in the same cycle. IF_valid_o marks a cycle in which IF_instr_o
//   carries an instruction for IF/ID. IF/ID stalls it through stall_i; while
//   stalled, the same word is presented again every cycle.
//
// Ports:
//   clk                in   clock, rising-edge
//   rst                in   asynchronous active-low reset
//   stall_i            in   IF/ID cannot accept an instruction
//   redirect_i         in   taken branch/jump from EX
//   redirect_jalr_i    in   redirect is a JALR (target LSB cleared)
//   redirect_target_i  in   [31:0] redirect target
//   imem_resp_i        in   instruction memory response
//   imem_rdata_i       in   [31:0] instruction memory data
//   imem_read_o        out  instruction memory read request
//   IF_PC_write_o      out  PC register load enable
//   IF_pcmux_sel_o     out  PC mux select (pcmux_sel_t)
//   IF_alu_out_o       out  [31:0] PC mux target input
//   IF_valid_o         out  instruction valid to IF/ID
//   IF_instr_o         out  [31:0] instruction to IF/ID
//   state_o            out  current FSM state (debug)
//
// Optional feature (macro FETCH_CTRL_PERF_EN):
//   perf_fetch_o   out [31:0]  valid instructions delivered
//   perf_squash_o  out [31:0]  responses dropped because of a redirect
//   perf_stall_o   out [31:0]  cycles spent in HOLD
//   All three counters saturate at 0xFFFFFFFF and reset to 0.
// -----------------------------------------------------------------------------

package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        pc_plus4 = 2'd0,
        alu_out  = 2'd1,
        alu_mod2 = 2'd2
    } pcmux_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         redirect_i,
    input  logic         redirect_jalr_i,
    input  logic [31:0]  redirect_target_i,
    input  logic         imem_resp_i,
    input  logic [31:0]  imem_rdata_i,
    output logic         imem_read_o,
    output logic         IF_PC_write_o,
    output pcmux_sel_t   IF_pcmux_sel_o,
    output logic [31:0]  IF_alu_out_o,
    output logic         IF_valid_o,
    output logic [31:0]  IF_instr_o,
    output fetch_state_t state_o
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]  perf_fetch_o,
    output logic [31:0]  perf_squash_o,
    output logic [31:0]  perf_stall_o
`endif
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    fetch_state_t state_q;
    fetch_state_t state_d;

    // The pending redirect is written only while a read is outstanding. It is
    // consumed by the response that ends that read.
    logic         pend_valid_q;
    logic         pend_jalr_q;
    logic [31:0]  pend_target_q;

    logic [31:0]  hold_q;

    // Strobes from the next-state logic into the storage registers.
    logic         pend_set;
    logic         pend_clr;
    logic         hold_load;

    // A redirect raised in the same cycle as the response takes precedence
    // over the stored one, because it is the newer one.
    logic         redir_any;
    logic         redir_jalr;
    logic [31:0]  redir_target;

    assign redir_any    = redirect_i | pend_valid_q;
    assign redir_jalr   = redirect_i ? redirect_jalr_i   : pend_jalr_q;
    assign redir_target = redirect_i ? redirect_target_i : pend_target_q;

    assign state_o = state_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        imem_read_o    = 1'b0;
        IF_PC_write_o  = 1'b0;
        IF_pcmux_sel_o = pc_plus4;
        IF_alu_out_o   = 32'h0;
        IF_valid_o     = 1'b0;
        IF_instr_o     = 32'h0;
        pend_set       = 1'b0;
        pend_clr       = 1'b0;
        hold_load      = 1'b0;

        case (state_q)
            // One quiet cycle after reset. Any response still in flight from
            // before reset arrives here and is ignored.
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                imem_read_o = 1'b1;
                if (!imem_resp_i) begin
                    // The read is still outstanding. The PC must not move, so
                    // a redirect is only recorded. A later redirect overwrites
                    // it.
                    if (redirect_i) begin
                        pend_set = 1'b1;
                    end
                end else if (redir_any) begin
                    // The word belongs to the wrong path. Drop it and steer
                    // the PC to the target.
                    IF_PC_write_o  = 1'b1;
                    IF_pcmux_sel_o = redir_jalr ? alu_mod2 : alu_out;
                    IF_alu_out_o   = redir_target;
                    pend_clr       = 1'b1;
                end else if (!stall_i) begin
                    IF_valid_o    = 1'b1;
                    IF_instr_o    = imem_rdata_i;
                    IF_PC_write_o = 1'b1;
                end else begin
                    // The word is presented now and kept. The PC does not
                    // advance until IF/ID takes the word.
                    IF_valid_o = 1'b1;
                    IF_instr_o = imem_rdata_i;
                    hold_load  = 1'b1;
                    state_d    = HOLD;
                end
            end

            HOLD: begin
                if (redirect_i) begin
                    IF_PC_write_o  = 1'b1;
                    IF_pcmux_sel_o = redirect_jalr_i ? alu_mod2 : alu_out;
                    IF_alu_out_o   = redirect_target_i;
                    state_d        = FETCH;
                end else begin
                    IF_valid_o = 1'b1;
                    IF_instr_o = hold_q;
                    if (!stall_i) begin
                        IF_PC_write_o = 1'b1;
                        state_d       = FETCH;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pending redirect register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_q  <= 1'b0;
            pend_jalr_q   <= 1'b0;
            pend_target_q <= 32'h0;
        end else if (pend_set) begin
            pend_valid_q  <= 1'b1;
            pend_jalr_q   <= redirect_jalr_i;
            pend_target_q <= redirect_target_i;
        end else if (pend_clr) begin
            pend_valid_q  <= 1'b0;
            pend_jalr_q   <= 1'b0;
            pend_target_q <= 32'h0;
        end
    end

    // -------------------------------------------------------------------------
    // Hold register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= 32'h0;
        end else if (hold_load) begin
            hold_q <= imem_rdata_i;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
    logic ev_fetch;
    logic ev_squash;
    logic ev_stall;

    // A word re-presented from HOLD is not counted again. It was counted
    // when its response was accepted in FETCH.
    always_comb begin
        ev_fetch  = 1'b0;
        ev_squash = 1'b0;
        ev_stall  = 1'b0;
        if (state_q == FETCH && imem_resp_i) begin
            ev_fetch  = !redir_any;
            ev_squash = redir_any;
        end
        if (state_q == HOLD) begin
            ev_stall = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_o  <= 32'h0;
            perf_squash_o <= 32'h0;
            perf_stall_o  <= 32'h0;
        end else begin
            if (ev_fetch && perf_fetch_o != 32'hFFFF_FFFF) begin
                perf_fetch_o <= perf_fetch_o + 32'd1;
            end
            if (ev_squash && perf_squash_o != 32'hFFFF_FFFF) begin
                perf_squash_o <= perf_squash_o + 32'd1;
            end
            if (ev_stall && perf_stall_o != 32'hFFFF_FFFF) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl
//
// The drivers apply one cycle of inputs just after a rising edge. Each driver
// also pushes the hand-computed output vector for that cycle into exp_q. A
// separate monitor pops and compares on each falling edge. A small PC register
// driven by the DUT's PC controls lets the bench check where the PC ends up.
// -----------------------------------------------------------------------------

module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int W = 71;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         stall_i = 1'b0;
    logic         redirect_i = 1'b0;
    logic         redirect_jalr_i = 1'b0;
    logic [31:0]  redirect_target_i = 32'h0;
    logic         imem_resp_i = 1'b0;
    logic [31:0]  imem_rdata_i = 32'h0;
    logic         imem_read_o;
    logic         IF_PC_write_o;
    pcmux_sel_t   IF_pcmux_sel_o;
    logic [31:0]  IF_alu_out_o;
    logic         IF_valid_o;
    logic [31:0]  IF_instr_o;
    fetch_state_t dut_state;

    fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .redirect_i        (redirect_i),
        .redirect_jalr_i   (redirect_jalr_i),
        .redirect_target_i (redirect_target_i),
        .imem_resp_i       (imem_resp_i),
        .imem_rdata_i      (imem_rdata_i),
        .imem_read_o       (imem_read_o),
        .IF_PC_write_o     (IF_PC_write_o),
        .IF_pcmux_sel_o    (IF_pcmux_sel_o),
        .IF_alu_out_o      (IF_alu_out_o),
        .IF_valid_o        (IF_valid_o),
        .IF_instr_o        (IF_instr_o),
        .state_o           (dut_state)
    );

    // PC register as the datapath would build it around the controller.
    logic [31:0] pc;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= 32'h0;
        end else if (IF_PC_write_o) begin
            case (IF_pcmux_sel_o)
                pc_plus4: pc <= pc + 32'd4;
                alu_out:  pc <= IF_alu_out_o;
                alu_mod2: pc <= IF_alu_out_o & ~32'h1;
                default:  pc <= 32'hBAD0_BAD0;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    // Packs one cycle of outputs in this order:
    // read, pc_write, sel, alu, valid, instr, state.
    function automatic logic [W-1:0] ov(input logic rd, input logic pw,
                                        input logic [1:0] sel,
                                        input logic [31:0] alu,
                                        input logic v, input logic [31:0] ins,
                                        input logic [1:0] st);
        return {rd, pw, sel, alu, v, ins, st};
    endfunction

    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_act;
    string        mon_name;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = ov(imem_read_o, IF_PC_write_o, IF_pcmux_sel_o,
                          IF_alu_out_o, IF_valid_o, IF_instr_o, dut_state);
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s: got rd=%b pw=%b sel=%0d alu=%h v=%b ins=%h st=%0d, expected rd=%b pw=%b sel=%0d alu=%h v=%b ins=%h st=%0d",
                         mon_name, mon_act[70], mon_act[69], mon_act[68:67],
                         mon_act[66:35], mon_act[34], mon_act[33:2], mon_act[1:0],
                         mon_exp[70], mon_exp[69], mon_exp[68:67],
                         mon_exp[66:35], mon_exp[34], mon_exp[33:2], mon_exp[1:0]);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic drive(input logic st, input logic rd, input logic jl,
                         input logic [31:0] tg, input logic rs,
                         input logic [31:0] dat, input logic [W-1:0] e,
                         input string nm);
        stall_i           = st;
        redirect_i        = rd;
        redirect_jalr_i   = jl;
        redirect_target_i = tg;
        imem_resp_i       = rs;
        imem_rdata_i      = dat;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step(input logic st, input logic rd, input logic jl,
                        input logic [31:0] tg, input logic rs,
                        input logic [31:0] dat, input logic [W-1:0] e,
                        input string nm);
        @(posedge clk);
        #1;
        drive(st, rd, jl, tg, rs, dat, e, nm);
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    logic [W-1:0] e_wait;
    logic [W-1:0] e_idle;

    initial begin
        e_wait = ov(1'b1, 1'b0, pc_plus4, 32'h0, 1'b0, 32'h0, FETCH);
        e_idle = ov(1'b0, 1'b0, pc_plus4, 32'h0, 1'b0, 32'h0, IDLE);

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {31'h0, imem_read_o | IF_PC_write_o | IF_valid_o}, 32'h0);
        check("reset_alu", IF_alu_out_o, 32'h0);
        check("reset_state", {30'h0, dut_state}, {30'h0, IDLE});

        // A stale response while in IDLE is ignored. After that there are
        // back-to-back fetches.
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 1, 32'h0000_0013, e_idle, "idle_stale_resp");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 32'h0, 1, 32'h0000_0013,
                 ov(1, 1, pc_plus4, 32'h0, 1, 32'h0000_0013, FETCH), "seq_fetch");
        end

        // A redirect during a slow response waits for that response.
        step(0, 1, 0, 32'h0000_0400, 0, 32'h0, e_wait, "redir_capture");
        check("pc_after_seq", pc, 32'h0000_000C);
        step(0, 0, 0, 32'h0, 0, 32'h0, e_wait, "redir_wait1");
        step(0, 0, 0, 32'h0, 0, 32'h0, e_wait, "redir_wait2");
        step(0, 0, 0, 32'h0, 1, 32'hAAAA_0001,
             ov(1, 1, alu_out, 32'h0000_0400, 0, 32'h0, FETCH), "redir_resp");
        step(0, 0, 0, 32'h0, 0, 32'h0, e_wait, "post_redir");
        check("pc_redirect", pc, 32'h0000_0400);

        // A later pending redirect overwrites an earlier one, including its
        // jalr flag.
        step(0, 1, 0, 32'h0000_0500, 0, 32'h0, e_wait, "redir_a");
        step(0, 1, 1, 32'h0000_0601, 0, 32'h0, e_wait, "redir_b");
        step(0, 0, 0, 32'h0, 1, 32'h0000_0077,
             ov(1, 1, alu_mod2, 32'h0000_0601, 0, 32'h0, FETCH), "redir_overwrite");
        step(0, 0, 0, 32'h0, 0, 32'h0, e_wait, "post_overwrite");
        check("pc_overwrite", pc, 32'h0000_0600);

        // A jalr redirect coincides with the response.
        step(0, 1, 1, 32'h0000_0123, 1, 32'h0000_0033,
             ov(1, 1, alu_mod2, 32'h0000_0123, 0, 32'h0, FETCH), "jalr_resp");
        step(0, 0, 0, 32'h0, 0, 32'h0, e_wait, "post_jalr");
        check("pc_jalr", pc, 32'h0000_0122);

        // A stall lasts 4 cycles at the response, then is released.
        step(1, 0, 0, 32'h0, 1, 32'hDEAD_BEEF,
             ov(1, 0, pc_plus4, 32'h0, 1, 32'hDEAD_BEEF, FETCH), "stall_resp");
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 32'h0, 0, 32'h1111_1111,
                 ov(0, 0, pc_plus4, 32'h0, 1, 32'hDEAD_BEEF, HOLD), "hold_stalled");
        end
        step(0, 0, 0, 32'h0, 0, 32'h1111_1111,
             ov(0, 1, pc_plus4, 32'h0, 1, 32'hDEAD_BEEF, HOLD), "hold_release");
        step(0, 0, 0, 32'h0, 0, 32'h0, e_wait, "after_hold");
        check("pc_hold_release", pc, 32'h0000_0126);

        // In HOLD, a redirect beats a stall.
        step(1, 0, 0, 32'h0, 1, 32'hCAFE_F00D,
             ov(1, 0, pc_plus4, 32'h0, 1, 32'hCAFE_F00D, FETCH), "stall_resp2");
        step(1, 1, 0, 32'h0000_0800, 0, 32'h0,
             ov(0, 1, alu_out, 32'h0000_0800, 0, 32'h0, HOLD), "hold_redirect");
        step(0, 0, 0, 32'h0, 0, 32'h0, e_wait, "after_hold_redirect");
        check("pc_hold_redirect", pc, 32'h0000_0800);

        // A pending redirect beats a stall at the response.
        step(0, 1, 0, 32'h0000_0900, 0, 32'h0, e_wait, "redir_c");
        step(1, 0, 0, 32'h0, 1, 32'h0000_0044,
             ov(1, 1, alu_out, 32'h0000_0900, 0, 32'h0, FETCH), "pend_over_stall");
        step(0, 0, 0, 32'h0, 0, 32'h0, e_wait, "after_pend");
        check("pc_pend", pc, 32'h0000_0900);

        // Reset is asserted between edges while a request is outstanding and
        // a redirect is pending.
        step(0, 1, 0, 32'h0000_0A00, 0, 32'h0, e_wait, "redir_d");
        @(posedge clk);
        #3;
        imem_resp_i  = 1'b1;
        imem_rdata_i = 32'h0000_0055;
        redirect_i   = 1'b0;
        rst          = 1'b0;
        #1;
        check("async_rst_read", {31'h0, imem_read_o}, 32'h0);
        check("async_rst_pcw", {31'h0, IF_PC_write_o}, 32'h0);
        check("async_rst_sel", {30'h0, IF_pcmux_sel_o}, {30'h0, pc_plus4});
        check("async_rst_alu", IF_alu_out_o, 32'h0);
        check("async_rst_valid", {31'h0, IF_valid_o}, 32'h0);
        check("async_rst_instr", IF_instr_o, 32'h0);
        check("async_rst_state", {30'h0, dut_state}, {30'h0, IDLE});

        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 1, 32'h0000_0055, e_idle, "stale_after_rst");
        // The pending redirect was cleared by reset, so this is a normal fetch.
        step(0, 0, 0, 32'h0, 1, 32'h0000_0066,
             ov(1, 1, pc_plus4, 32'h0, 1, 32'h0000_0066, FETCH), "fetch_after_rst");
        step(0, 0, 0, 32'h0, 0, 32'h0, e_wait, "final_wait");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
